ball_motion_controller: RTL

BALL_MOTION_CONTROLLER -- requirements
Module: ball_motion_controller

---
 rtl/ball_motion_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ball_motion_controller.sv
// Moves a square ball around the visible area once per video frame, bouncing off
// the walls, with optional single-step operation and a registered ball-pixel flag.
module ball_motion_controller #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 16,
  parameter int SPEED     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_vsync,
  input  logic       i_de,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_enable,
  input  logic       i_step_req,
  output logic       o_step_ack,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic       o_draw_ball,
  output logic       o_bounce,
  output logic [7:0] o_frame_cnt
);

  // 11-bit arithmetic keeps pos + SPEED from wrapping near the right/bottom wall.
  localparam logic [10:0] X_LIM  = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] Y_LIM  = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] X_INIT = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] Y_INIT = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] SPD    = 11'(SPEED);
  localparam logic [10:0] SZ     = 11'(BALL_SIZE);

  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, DONE} state_t;

  state_t      state;
  logic        vsync_q;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic        dir_right;
  logic        dir_down;
  logic        pending;
  logic        step_active;

  logic        frame_start;
  logic        step_req_valid;
  logic [10:0] x_fwd, y_fwd;
  logic [10:0] px, py;
  logic        in_x, in_y;

  assign frame_start    = vsync_q & ~i_vsync;
  assign step_req_valid = i_step_req & ~i_enable;
  assign x_fwd          = pos_x + SPD;
  assign y_fwd          = pos_y + SPD;
  assign px             = {1'b0, i_x};
  assign py             = {1'b0, i_y};
  assign in_x           = (px >= pos_x) && (px < pos_x + SZ);
  assign in_y           = (py >= pos_y) && (py < pos_y + SZ);

  assign o_ball_x = pos_x[9:0];
  assign o_ball_y = pos_y[9:0];

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the values from before the edge, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_q     <= 1'b1;
      pos_x       <= X_INIT;
      pos_y       <= Y_INIT;
      dir_right   <= 1'b1;
      dir_down    <= 1'b1;
      pending     <= 1'b0;
      step_active <= 1'b0;
      o_frame_cnt <= 8'd0;
      o_draw_ball <= 1'b0;
      o_bounce    <= 1'b0;
      o_step_ack  <= 1'b0;
    end else begin
      vsync_q     <= i_vsync;
      o_draw_ball <= i_de & in_x & in_y;
      // Pulses default low; the state that raises one overrides below.
      o_bounce    <= 1'b0;
      o_step_ack  <= 1'b0;

      if (frame_start) o_frame_cnt <= o_frame_cnt + 8'd1;
      if (step_req_valid) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start && (i_enable || pending || step_req_valid)) begin
            state       <= MOVE_X;
            step_active <= pending | step_req_valid;
          end
        end
        MOVE_X: begin
          if (dir_right) begin
            if (x_fwd >= X_LIM) begin
              pos_x     <= X_LIM;
              dir_right <= 1'b0;
              o_bounce  <= 1'b1;
            end else begin
              pos_x <= x_fwd;
            end
          end else begin
            if (pos_x <= SPD) begin
              pos_x     <= 11'd0;
              dir_right <= 1'b1;
              o_bounce  <= 1'b1;
            end else begin
              pos_x <= pos_x - SPD;
            end
          end
          state <= MOVE_Y;
        end
        MOVE_Y: begin
          if (dir_down) begin
            if (y_fwd >= Y_LIM) begin
              pos_y    <= Y_LIM;
              dir_down <= 1'b0;
              o_bounce <= 1'b1;
            end else begin
              pos_y <= y_fwd;
            end
          end else begin
            if (pos_y <= SPD) begin
              pos_y    <= 11'd0;
              dir_down <= 1'b1;
              o_bounce <= 1'b1;
            end else begin
              pos_y <= pos_y - SPD;
            end
          end
          state <= DONE;
        end
        DONE: begin
          // Requests that arrived during the update merge into the step just served.
          if (step_active) begin
            o_step_ack <= 1'b1;
            pending    <= 1'b0;
          end
          step_active <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
